oh_hs_rx: RTL and testbench

// - Destination-domain receiver of a 4-phase req/ack clock-crossing handshake.
// - Sits directly downstream of the single-bit synchronizer on the req line and consumes its output.
// - Captures the source's stable data bus and presents it as a valid/ready stream to local logic.
// - Returns ack to the source domain, where the source re-synchronizes it.
// - Keeps a wrapping transfer count and a sticky protocol-error flag.

---
 rtl/oh_hs_rx.sv | 83 ++++++++
 tb/tb_oh_hs_rx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oh_hs_rx.sv
// Destination-side receiver for a 4-phase req/ack clock-crossing handshake.
// Captures the source's held data bus and presents it locally as a valid/ready stream.
module oh_hs_rx #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_sync,
  input  logic [DW-1:0] din,
  input  logic          ready,
  input  logic          err_clr,
  output logic          valid,
  output logic [DW-1:0] dout,
  output logic          ack,
  output logic          busy,
  output logic [CW-1:0] count,
  output logic          err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      valid <= 1'b0;
      ack   <= 1'b0;
      busy  <= 1'b0;
      count <= '0;
      err   <= 1'b0;
      dout  <= '0;
    end else begin
      // A fresh error is assigned later in this block, so it overrides the clear.
      if (err_clr)
        err <= 1'b0;

      case (state)
        IDLE: begin
          if (req_sync) begin
            dout  <= din;
            valid <= 1'b1;
            busy  <= 1'b1;
            state <= HOLD;
          end
        end

        HOLD: begin
          // Early req drop is flagged, but the captured word is still handed over.
          if (!req_sync)
            err <= 1'b1;
          if (ready) begin
            valid <= 1'b0;
            ack   <= 1'b1;
            count <= count + CW'(1);
            state <= ACK;
          end
        end

        ACK: begin
          if (!req_sync) begin
            ack   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          valid <= 1'b0;
          ack   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oh_hs_rx.sv
// Bench for oh_hs_rx: directed protocol scenarios plus a randomized two-clock streaming run.
`timescale 1ns/1ps
module tb_oh_hs_rx;

  logic        clk = 1'b0;
  logic        src_clk = 1'b0;
  logic        reset;
  logic        req_drv;
  logic [31:0] din_drv;
  logic        ready;
  logic        err_clr;
  logic        mode;
  logic        start;

  logic        req_src = 1'b0;
  logic [31:0] din_src = '0;
  logic        r1 = 1'b0, r2 = 1'b0;
  logic        a1 = 1'b0, a2 = 1'b0;

  logic        req_sync;
  logic [31:0] din;

  logic        valid, ack, busy, err;
  logic [31:0] dout;
  logic [15:0] count;
  logic        valid_w, ack_w, busy_w, err_w;
  logic [31:0] dout_w;
  logic [3:0]  count_w;

  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;
  always #7 src_clk = ~src_clk;

  assign req_sync = mode ? r2 : req_drv;
  assign din      = mode ? din_src : din_drv;

  oh_hs_rx #(.DW(32), .CW(16)) dut (
    .clk(clk), .reset(reset), .req_sync(req_sync), .din(din), .ready(ready),
    .err_clr(err_clr), .valid(valid), .dout(dout), .ack(ack), .busy(busy),
    .count(count), .err(err)
  );

  oh_hs_rx #(.DW(32), .CW(4)) dut_w (
    .clk(clk), .reset(reset), .req_sync(req_sync), .din(din), .ready(ready),
    .err_clr(err_clr), .valid(valid_w), .dout(dout_w), .ack(ack_w), .busy(busy_w),
    .count(count_w), .err(err_w)
  );

  // Two-flop synchronizers for the source model, one per direction.
  always @(posedge clk) begin
    r1 <= req_src;
    r2 <= r1;
  end

  always @(posedge src_clk) begin
    a1 <= ack;
    a2 <= a1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_ack"},   ack,   0);
    check({tag, "_busy"},  busy,  0);
    check({tag, "_count"}, count, 0);
    check({tag, "_err"},   err,   0);
    check({tag, "_dout"},  dout,  0);
    check({tag, "_countw"}, count_w, 0);
  endtask

  // One complete transfer with a random amount of backpressure.
  task automatic xfer(input logic [31:0] d);
    int wait_n;
    req_drv = 1'b1;
    din_drv = d;
    ready   = 1'b0;
    tick();
    check("xfer_valid", valid, 1);
    check("xfer_dout", dout, d);
    wait_n = $urandom_range(0, 3);
    repeat (wait_n) tick();
    ready = 1'b1;
    tick();
    model_cnt++;
    check("xfer_ack", ack, 1);
    check("xfer_count", count, model_cnt % 65536);
    req_drv = 1'b0;
    ready   = 1'b0;
    tick();
    check("xfer_ack_drop", ack, 0);
  endtask

  // Source-domain model: raise req with stable data, wait ack, drop req, wait ack low.
  initial begin
    int guard;
    wait (start);
    for (int i = 0; i < 100; i++) begin
      guard = 0;
      while (a2 && guard < 1000) begin @(posedge src_clk); guard++; end
      @(posedge src_clk);
      din_src = $urandom;
      exp_q.push_back(din_src);
      req_src = 1'b1;
      guard = 0;
      while (!a2 && guard < 1000) begin @(posedge src_clk); guard++; end
      req_src = 1'b0;
    end
  end

  initial begin
    logic [31:0] held;
    logic [31:0] w;
    int got;
    int cyc;

    reset = 1'b1; req_drv = 1'b0; din_drv = '0; ready = 1'b0;
    err_clr = 1'b0; mode = 1'b0; start = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    check_reset("rst");

    // Single transfer with ready already high.
    req_drv = 1'b1; din_drv = 32'hA5A5_0001; ready = 1'b1;
    tick();
    check("single_valid", valid, 1);
    check("single_dout", dout, 32'hA5A5_0001);
    check("single_busy", busy, 1);
    check("single_ack_early", ack, 0);
    tick();
    model_cnt++;
    check("single_ack", ack, 1);
    check("single_valid_drop", valid, 0);
    check("single_count", count, 1);
    req_drv = 1'b0;
    tick();
    check("single_ack_drop", ack, 0);
    check("single_busy_drop", busy, 0);
    ready = 1'b0;

    // Backpressure: din wiggles while held, must not leak into dout.
    held = $urandom;
    req_drv = 1'b1; din_drv = held;
    tick();
    for (int i = 0; i < 10; i++) begin
      din_drv = $urandom;
      tick();
      check("bp_valid", valid, 1);
      check("bp_dout", dout, held);
      check("bp_ack", ack, 0);
    end
    ready = 1'b1;
    tick();
    model_cnt++;
    check("bp_ack_rise", ack, 1);
    check("bp_count", count, model_cnt);
    req_drv = 1'b0; ready = 1'b0;
    tick();

    // Protocol error: req drops while the word is still held.
    held = $urandom;
    req_drv = 1'b1; din_drv = held;
    tick();
    req_drv = 1'b0;
    tick();
    check("perr_err", err, 1);
    check("perr_valid", valid, 1);
    tick();
    check("perr_dout", dout, held);
    ready = 1'b1;
    tick();
    model_cnt++;
    check("perr_ack", ack, 1);
    check("perr_count", count, model_cnt);
    ready = 1'b0;
    tick();
    check("perr_idle_ack", ack, 0);
    check("perr_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("perr_clr", err, 0);

    // Clear coinciding with a new error: the error wins.
    req_drv = 1'b1; din_drv = $urandom;
    tick();
    req_drv = 1'b0; err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("perr_clr_vs_new", err, 1);
    ready = 1'b1;
    tick();
    model_cnt++;
    ready = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("perr_clr2", err, 0);
    check("perr_count2", count, model_cnt);

    // Counter wrap on the CW=4 instance after 17 fresh transfers.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_cnt = 0;
    for (int i = 0; i < 17; i++) xfer($urandom);
    check("wrap_count_w", count_w, model_cnt % 16);
    check("wrap_count", count, model_cnt);

    // Reset while holding a word.
    req_drv = 1'b1; din_drv = $urandom;
    tick();
    check("rhold_valid", valid, 1);
    reset = 1'b1;
    tick();
    check_reset("rst_hold");
    held = $urandom;
    din_drv = held;
    reset = 1'b0;
    tick();
    check("rhold_recapture", dout, held);
    check("rhold_valid2", valid, 1);

    // Reset while acknowledging.
    ready = 1'b1;
    tick();
    check("rack_ack", ack, 1);
    reset = 1'b1; ready = 1'b0; req_drv = 1'b0;
    tick();
    check_reset("rst_ack");
    reset = 1'b0;
    model_cnt = 0;
    repeat (3) tick();

    // Streaming through the two-flop source model with random ready.
    mode = 1'b1;
    repeat (3) tick();
    start = 1'b1;
    got = 0;
    cyc = 0;
    while (got < 100 && cyc < 20000) begin
      ready = 1'($urandom_range(0, 1));
      if (valid && ready) begin
        check("stream_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("stream_data", dout, w);
        end
        got++;
      end
      tick();
      cyc++;
    end
    ready = 1'b0;
    check("stream_words", got, 100);
    check("stream_left", exp_q.size(), 0);
    check("stream_count", count, 100);
    check("stream_count_w", count_w, 100 % 16);
    check("stream_err", err, 0);
    cyc = 0;
    while (busy && cyc < 100) begin tick(); cyc++; end
    check("stream_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
